// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: front end of the filter processor pipeline.
// Fetches one instruction word at a time from instruction memory, splits it
// into decoder fields and presents them through a valid/ready handshake.
// A NOP bubble is inserted on load-use hazards; taken branches redirect the PC.
//
// Handshake: a transfer happens on a cycle where issue_valid & issue_ready are
// both high. While issue_valid=1 and issue_ready=0 every issue output holds.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_addr/imem_req  fetch address and single-cycle fetch request
//   imem_rdata/rvalid   fetched word and its valid strobe
//   issue_valid/ready   downstream handshake
//   opcode..imm         decoded instruction fields
//   issue_pc            PC of the issued instruction (0 for a bubble)
//   branch_taken/target redirect pulse and destination from execute
//   stall_load          high while a load-use bubble is presented
//   dbg_state           current FSM state for observation
module instr_fetch_issue #(
  parameter int INSTR_W = 24,
  parameter int PC_W = 10,
  parameter int unsigned RST_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         opcode,
  output logic [1:0]         cmp_flag,
  output logic [3:0]         rd,
  output logic [3:0]         ra,
  output logic [3:0]         rb,
  output logic [9:0]         imm,
  output logic [PC_W-1:0]    issue_pc,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               stall_load,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_BUBBLE = 3'd3,
    S_ISSUE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'hF;
  localparam logic [3:0] OP_LOAD = 4'hC;

  state_t              r_state;
  state_t              w_next;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_hold;
  logic                r_last_load;
  logic [3:0]          r_last_rd;
  logic                r_drop;

  logic                w_branch;
  logic                w_xfer;
  logic                w_reads_a;
  logic                w_reads_b;
  logic                w_hazard;
  logic [3:0]          w_new_op;
  logic [3:0]          w_new_ra;
  logic [3:0]          w_new_rb;

  // Branches are ignored while idle (nothing is in flight yet).
  assign w_branch = branch_taken && (r_state != S_IDLE);
  assign w_xfer   = issue_valid && issue_ready;

  // Hazard is judged on the word arriving from memory, before it is held.
  assign w_new_op = imem_rdata[23:20];
  assign w_new_ra = imem_rdata[13:10];
  assign w_new_rb = imem_rdata[9:6];

  always_comb begin
    w_reads_a = !(w_new_op inside {4'hB, 4'hE, 4'hF});
    w_reads_b = !(w_new_op inside {4'h6, 4'hB, 4'hC, 4'hE, 4'hF});
    w_hazard  = r_last_load &&
                ((w_reads_a && (w_new_ra == r_last_rd)) ||
                 (w_reads_b && (w_new_rb == r_last_rd)));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = S_FETCH;
      // The request is already out, so a branch here must still wait it out.
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (w_branch || r_drop) w_next = S_FETCH;
          else if (w_hazard)      w_next = S_BUBBLE;
          else                    w_next = S_ISSUE;
        end
      end
      S_BUBBLE: begin
        if (w_branch)    w_next = S_FETCH;
        else if (w_xfer) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_branch || w_xfer) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= PC_W'(RST_PC);
      r_hold      <= '0;
      r_last_load <= 1'b0;
      r_last_rd   <= 4'd0;
      r_drop      <= 1'b0;
    end else begin
      if (r_state == S_WAIT && imem_rvalid) r_hold <= imem_rdata;

      // drop marks the single outstanding response as stale after a redirect.
      if (r_state == S_FETCH && w_branch) begin
        r_drop <= 1'b1;
      end else if (r_state == S_WAIT) begin
        if (imem_rvalid)   r_drop <= 1'b0;
        else if (w_branch) r_drop <= 1'b1;
      end

      // A branch in the same cycle as a handshake still wins the PC.
      if (w_branch) begin
        r_pc        <= branch_target;
        r_last_load <= 1'b0;
      end else if (r_state == S_ISSUE && w_xfer) begin
        r_pc        <= r_pc + PC_W'(1);
        r_last_load <= (r_hold[23:20] == OP_LOAD);
        r_last_rd   <= r_hold[17:14];
      end else if (r_state == S_BUBBLE && w_xfer) begin
        r_last_load <= 1'b0;
      end
    end
  end

  // Output logic: a pure decode of registered state, so outputs stay stable
  // for as long as the state is held under backpressure.
  always_comb begin
    imem_req    = (r_state == S_FETCH);
    imem_addr   = r_pc;
    issue_valid = 1'b0;
    stall_load  = 1'b0;
    opcode      = OP_NOP;
    cmp_flag    = 2'd0;
    rd          = 4'd0;
    ra          = 4'd0;
    rb          = 4'd0;
    imm         = 10'd0;
    issue_pc    = '0;
    unique case (r_state)
      S_BUBBLE: begin
        issue_valid = 1'b1;
        stall_load  = 1'b1;
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        opcode      = r_hold[23:20];
        cmp_flag    = r_hold[19:18];
        rd          = r_hold[17:14];
        ra          = r_hold[13:10];
        rb          = r_hold[9:6];
        imm         = r_hold[9:0];
        issue_pc    = r_pc;
      end
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule
